// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// mstatus bit positions, cause codes and controller state encodings.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h000;
  localparam logic [11:0] CSR_MEPC    = 12'h041;
  localparam logic [11:0] CSR_MCAUSE  = 12'h042;
  localparam logic [11:0] CSR_MTVEC   = 12'h005;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [4:0] CODE_IFETCH  = 5'd0;
  localparam logic [4:0] CODE_ILLEGAL = 5'd2;
  localparam logic [4:0] CODE_LDMIS   = 5'd4;
  localparam logic [4:0] CODE_ECALL   = 5'd11;
  localparam logic [4:0] CODE_IRQ_EXT = 5'd11;
  localparam logic [4:0] CODE_IRQ_SW  = 5'd3;
  localparam logic [4:0] CODE_IRQ_TMR = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_T_EPC   = 3'd1,
    ST_T_CAUSE = 3'd2,
    ST_T_STAT  = 3'd3,
    ST_T_VEC   = 3'd4,
    ST_M_STAT  = 3'd5,
    ST_M_EPC   = 3'd6
  } state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap source priority encoder: picks the winning exception or
// (if globally enabled) interrupt and reports its cause code.
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic       exc_ifetch,
  input  logic       exc_illegal,
  input  logic       exc_ldmis,
  input  logic       exc_ecall,
  input  logic       irq_ext,
  input  logic       irq_sw,
  input  logic       irq_tmr,
  input  logic       mie,
  output logic       take,
  output logic       irq,
  output logic [4:0] code
);

  always_comb begin
    take = 1'b0;
    irq  = 1'b0;
    code = 5'd0;
    // Any exception outranks every interrupt.
    if (exc_ifetch) begin
      take = 1'b1;
      code = CODE_IFETCH;
    end else if (exc_illegal) begin
      take = 1'b1;
      code = CODE_ILLEGAL;
    end else if (exc_ldmis) begin
      take = 1'b1;
      code = CODE_LDMIS;
    end else if (exc_ecall) begin
      take = 1'b1;
      code = CODE_ECALL;
    end else if (mie && irq_ext) begin
      take = 1'b1;
      irq  = 1'b1;
      code = CODE_IRQ_EXT;
    end else if (mie && irq_sw) begin
      take = 1'b1;
      irq  = 1'b1;
      code = CODE_IRQ_SW;
    end else if (mie && irq_tmr) begin
      take = 1'b1;
      irq  = 1'b1;
      code = CODE_IRQ_TMR;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer. Owns the single CSR port while it
// saves mepc/mcause/mstatus, then redirects the pipeline to mtvec or mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit VECTORED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            exc_ifetch,
  input  logic            exc_illegal,
  input  logic            exc_ldmis,
  input  logic            exc_ecall,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_tmr,
  input  logic            mret,
  input  logic [31:0]     csr_info,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_own,
  output logic            csr_w,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            take, irq;
  logic [4:0]      code;
  logic            latch_trap;
  logic            unused_info;

  // Only mstatus.MIE is consulted; the mip half is informational here.
  assign unused_info = ^{csr_info[31:MS_MIE+1], csr_info[MS_MIE-1:0]};

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r                      = ms;
    r[MS_MPIE]             = ms[MS_MIE];
    r[MS_MIE]              = 1'b0;
    r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r          = ms;
    r[MS_MIE]  = ms[MS_MPIE];
    r[MS_MPIE] = 1'b1;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] vec_target(input logic [XLEN-1:0] tvec,
                                                 input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] off;
    off = '0;
    if (VECTORED && cause[XLEN-1]) off[6:0] = {cause[4:0], 2'b00};
    return (tvec & {{(XLEN-2){1'b1}}, 2'b00}) + off;
  endfunction

  trap_prio_enc u_prio (
    .exc_ifetch  (exc_ifetch),
    .exc_illegal (exc_illegal),
    .exc_ldmis   (exc_ldmis),
    .exc_ecall   (exc_ecall),
    .irq_ext     (irq_ext),
    .irq_sw      (irq_sw),
    .irq_tmr     (irq_tmr),
    .mie         (csr_info[MS_MIE]),
    .take        (take),
    .irq         (irq),
    .code        (code)
  );

  always_comb begin
    cause_d            = '0;
    cause_d[XLEN-1]    = irq;
    cause_d[4:0]       = code;
  end

  always_comb begin
    state_d     = state_q;
    latch_trap  = 1'b0;
    stall       = 1'b0;
    csr_own     = 1'b0;
    csr_w       = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid && take) begin
          stall      = 1'b1;
          latch_trap = 1'b1;
          state_d    = ST_T_EPC;
        end else if (instr_valid && mret) begin
          stall   = 1'b1;
          state_d = ST_M_STAT;
        end
      end
      ST_T_EPC: begin
        stall     = 1'b1;
        csr_own   = 1'b1;
        csr_w     = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = epc_q;
        state_d   = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        stall     = 1'b1;
        csr_own   = 1'b1;
        csr_w     = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = ST_T_STAT;
      end
      ST_T_STAT: begin
        stall     = 1'b1;
        csr_own   = 1'b1;
        csr_w     = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = trap_mstatus(csr_rdata);
        state_d   = ST_T_VEC;
      end
      ST_T_VEC: begin
        stall       = 1'b1;
        csr_own     = 1'b1;
        csr_addr    = CSR_MTVEC;
        redirect    = 1'b1;
        redirect_pc = vec_target(csr_rdata, cause_q);
        state_d     = ST_IDLE;
      end
      ST_M_STAT: begin
        stall     = 1'b1;
        csr_own   = 1'b1;
        csr_w     = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mret_mstatus(csr_rdata);
        state_d   = ST_M_EPC;
      end
      ST_M_EPC: begin
        stall       = 1'b1;
        csr_own     = 1'b1;
        csr_addr    = CSR_MEPC;
        redirect    = 1'b1;
        redirect_pc = csr_rdata;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset silences the port immediately so an aborted sequence never writes or redirects.
    if (rst) begin
      state_d     = ST_IDLE;
      latch_trap  = 1'b0;
      stall       = 1'b0;
      csr_own     = 1'b0;
      csr_w       = 1'b0;
      csr_addr    = '0;
      csr_wdata   = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_trap) begin
        epc_q   <= pc;
        cause_q <= cause_d;
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small behavioural CSR file model.
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] pc;
  logic        exc_ifetch, exc_illegal, exc_ldmis, exc_ecall;
  logic        irq_ext, irq_sw, irq_tmr;
  logic        mret;
  logic [31:0] csr_info;
  logic [31:0] csr_rdata;
  logic        csr_own, csr_w;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;

  logic        tb_load;
  logic [31:0] ld_mstatus, ld_mepc, ld_mcause, ld_mtvec;
  logic [31:0] m_mstatus, m_mepc, m_mcause, m_mtvec;
  int          wr_mstatus, wr_mepc, wr_mcause;

  int n_checks;
  int n_fail;

  trap_ctrl #(.XLEN(32), .VECTORED(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .pc          (pc),
    .exc_ifetch  (exc_ifetch),
    .exc_illegal (exc_illegal),
    .exc_ldmis   (exc_ldmis),
    .exc_ecall   (exc_ecall),
    .irq_ext     (irq_ext),
    .irq_sw      (irq_sw),
    .irq_tmr     (irq_tmr),
    .mret        (mret),
    .csr_info    (csr_info),
    .csr_rdata   (csr_rdata),
    .csr_own     (csr_own),
    .csr_w       (csr_w),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model
  assign csr_info = {16'h0000, m_mstatus[15:0]};

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h000: csr_rdata = m_mstatus;
      12'h041: csr_rdata = m_mepc;
      12'h042: csr_rdata = m_mcause;
      12'h005: csr_rdata = m_mtvec;
      default: csr_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tb_load) begin
      m_mstatus  <= ld_mstatus;
      m_mepc     <= ld_mepc;
      m_mcause   <= ld_mcause;
      m_mtvec    <= ld_mtvec;
      wr_mstatus <= 0;
      wr_mepc    <= 0;
      wr_mcause  <= 0;
    end else if (csr_w) begin
      case (csr_addr)
        12'h000: begin m_mstatus <= csr_wdata; wr_mstatus <= wr_mstatus + 1; end
        12'h041: begin m_mepc    <= csr_wdata; wr_mepc    <= wr_mepc + 1;    end
        12'h042: begin m_mcause  <= csr_wdata; wr_mcause  <= wr_mcause + 1;  end
        default: ;
      endcase
    end
  end

  typedef struct {
    logic        vld;
    logic [3:0]  exc;   // {ifetch, illegal, ldmis, ecall}
    logic [2:0]  irq;   // {ext, sw, tmr}
    logic        mret;
    logic [31:0] ms0;
    logic [31:0] mepc0;
    logic [31:0] tvec;
    logic [31:0] pc;
    logic        exp_red;
    int          exp_lat;
    logic [31:0] exp_rpc;
    logic [31:0] exp_ms;
    logic [31:0] exp_mc;
    logic [31:0] exp_mepc;
  } vec_t;

  vec_t tv[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] e, input logic [2:0] q,
                       input logic m, input logic [31:0] p);
    instr_valid = v;
    {exc_ifetch, exc_illegal, exc_ldmis, exc_ecall} = e;
    {irq_ext, irq_sw, irq_tmr} = q;
    mret = m;
    pc = p;
  endtask

  task automatic preload(input logic [31:0] ms, input logic [31:0] ep,
                         input logic [31:0] mc, input logic [31:0] tvec);
    @(negedge clk);
    ld_mstatus = ms;
    ld_mepc    = ep;
    ld_mcause  = mc;
    ld_mtvec   = tvec;
    tb_load    = 1'b1;
    @(negedge clk);
    tb_load    = 1'b0;
  endtask

  int          lat, nred, nstall, nown;
  logic [31:0] rpc;
  logic        stall_after;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tb_load  = 1'b0;
    ld_mstatus = 32'h0; ld_mepc = 32'h0; ld_mcause = 32'h0; ld_mtvec = 32'h0;
    rst = 1'b1;
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 32'h0);

    tv[0]  = '{1'b1, 4'b0100, 3'b000, 1'b0, 32'h8,    32'h444, 32'h200,      32'h100, 1'b1, 4, 32'h200,  32'h1880, 32'h2,        32'h100};
    tv[1]  = '{1'b1, 4'b0000, 3'b001, 1'b0, 32'h8,    32'h444, 32'h200,      32'h140, 1'b1, 4, 32'h21C,  32'h1880, 32'h80000007, 32'h140};
    tv[2]  = '{1'b1, 4'b0001, 3'b100, 1'b0, 32'h8,    32'h444, 32'h200,      32'h180, 1'b1, 4, 32'h200,  32'h1880, 32'h0000000B, 32'h180};
    tv[3]  = '{1'b1, 4'b1111, 3'b111, 1'b0, 32'h8,    32'h444, 32'h200,      32'h1C0, 1'b1, 4, 32'h200,  32'h1880, 32'h0,        32'h1C0};
    tv[4]  = '{1'b1, 4'b0111, 3'b000, 1'b0, 32'h8,    32'h444, 32'h200,      32'h204, 1'b1, 4, 32'h200,  32'h1880, 32'h2,        32'h204};
    tv[5]  = '{1'b1, 4'b0011, 3'b000, 1'b0, 32'h8,    32'h444, 32'h200,      32'h208, 1'b1, 4, 32'h200,  32'h1880, 32'h4,        32'h208};
    tv[6]  = '{1'b1, 4'b0000, 3'b011, 1'b0, 32'h8,    32'h444, 32'h200,      32'h20C, 1'b1, 4, 32'h20C,  32'h1880, 32'h80000003, 32'h20C};
    tv[7]  = '{1'b1, 4'b0000, 3'b111, 1'b0, 32'h8,    32'h444, 32'h200,      32'h210, 1'b1, 4, 32'h22C,  32'h1880, 32'h8000000B, 32'h210};
    tv[8]  = '{1'b1, 4'b0000, 3'b000, 1'b1, 32'h1880, 32'h104, 32'h200,      32'h500, 1'b1, 2, 32'h104,  32'h1888, 32'h55,       32'h104};
    tv[9]  = '{1'b1, 4'b0100, 3'b000, 1'b1, 32'h8,    32'h444, 32'h200,      32'h300, 1'b1, 4, 32'h200,  32'h1880, 32'h2,        32'h300};
    tv[10] = '{1'b1, 4'b0000, 3'b000, 1'b1, 32'h0,    32'h444, 32'h200,      32'h504, 1'b1, 2, 32'h444,  32'h80,   32'h55,       32'h444};
    tv[11] = '{1'b1, 4'b0000, 3'b001, 1'b0, 32'h0,    32'h444, 32'h200,      32'h600, 1'b0, 0, 32'h0,    32'h0,    32'h55,       32'h444};
    tv[12] = '{1'b1, 4'b0000, 3'b100, 1'b0, 32'hA0F,  32'h444, 32'h201,      32'h220, 1'b1, 4, 32'h22C,  32'h1A87, 32'h8000000B, 32'h220};
    tv[13] = '{1'b1, 4'b0000, 3'b001, 1'b0, 32'h8,    32'h444, 32'hFFFFFFF0, 32'h230, 1'b1, 4, 32'h0000000C, 32'h1880, 32'h80000007, 32'h230};
    tv[14] = '{1'b0, 4'b0100, 3'b000, 1'b0, 32'h8,    32'h444, 32'h200,      32'h240, 1'b0, 0, 32'h0,    32'h8,    32'h55,       32'h444};
    tv[15] = '{1'b1, 4'b0000, 3'b001, 1'b1, 32'h1880, 32'h104, 32'h200,      32'h508, 1'b1, 2, 32'h104,  32'h1888, 32'h55,       32'h104};

    // Reset state, including a source active while reset is held
    preload(32'h0, 32'h0, 32'h0, 32'h200);
    @(negedge clk);
    check("rst stall",       {31'b0, stall},    32'h0);
    check("rst csr_own",     {31'b0, csr_own},  32'h0);
    check("rst csr_w",       {31'b0, csr_w},    32'h0);
    check("rst redirect",    {31'b0, redirect}, 32'h0);
    check("rst csr_addr",    {20'b0, csr_addr}, 32'h0);
    check("rst redirect_pc", redirect_pc,       32'h0);
    drive(1'b1, 4'b0100, 3'b000, 1'b0, 32'h100);
    #1;
    check("rst masks stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 32'h0);
    rst = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 16; i++) begin
      preload(tv[i].ms0, tv[i].mepc0, 32'h55, tv[i].tvec);
      drive(tv[i].vld, tv[i].exc, tv[i].irq, tv[i].mret, tv[i].pc);
      #1;
      check($sformatf("v%0d stall c0", i), {31'b0, stall}, {31'b0, tv[i].exp_red});
      @(posedge clk);
      #1;
      drive(1'b0, 4'b0000, 3'b000, 1'b0, 32'h0);
      lat = -1; nred = 0; rpc = 32'h0; stall_after = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (lat >= 0 && c == lat + 1) stall_after = stall;
        if (redirect) begin
          nred++;
          if (lat < 0) begin
            lat = c;
            rpc = redirect_pc;
          end
        end
      end
      check($sformatf("v%0d redirects", i), 32'(nred), {31'b0, tv[i].exp_red});
      if (tv[i].exp_red) begin
        check($sformatf("v%0d latency", i), 32'(lat), 32'(tv[i].exp_lat));
        check($sformatf("v%0d redirect_pc", i), rpc, tv[i].exp_rpc);
        check($sformatf("v%0d stall after", i), {31'b0, stall_after}, 32'h0);
      end
      check($sformatf("v%0d mstatus", i), m_mstatus, tv[i].exp_ms);
      check($sformatf("v%0d mcause", i), m_mcause, tv[i].exp_mc);
      check($sformatf("v%0d mepc", i), m_mepc, tv[i].exp_mepc);
    end

    // Timer interrupt held with MIE=0 for 10 cycles: never taken
    preload(32'h0, 32'h444, 32'h55, 32'h200);
    drive(1'b1, 4'b0000, 3'b001, 1'b0, 32'h700);
    nstall = 0; nown = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (stall) nstall++;
      if (csr_own) nown++;
      @(negedge clk);
    end
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 32'h0);
    check("mie0 stall cycles", 32'(nstall), 32'h0);
    check("mie0 own cycles", 32'(nown), 32'h0);
    check("mie0 mcause", m_mcause, 32'h55);

    // Reset during T_CAUSE aborts cleanly
    preload(32'h8, 32'h444, 32'h55, 32'h200);
    drive(1'b1, 4'b0100, 3'b000, 1'b0, 32'h100);
    @(posedge clk);
    #1;
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort csr_w gated", {31'b0, csr_w}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort stall", {31'b0, stall}, 32'h0);
    check("abort csr_own", {31'b0, csr_own}, 32'h0);
    nred = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (redirect) nred++;
    end
    check("abort redirects", 32'(nred), 32'h0);
    check("abort mcause", m_mcause, 32'h55);
    check("abort mepc", m_mepc, 32'h100);
    check("abort mstatus", m_mstatus, 32'h8);

    // Exception re-raised throughout the sequence is ignored
    preload(32'h8, 32'h444, 32'h55, 32'h200);
    drive(1'b1, 4'b0100, 3'b000, 1'b0, 32'h100);
    @(posedge clk);
    #1;
    drive(1'b1, 4'b0100, 3'b000, 1'b0, 32'h300);
    nred = 0; lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (redirect) begin
        nred++;
        if (lat < 0) lat = c;
      end
      if (c == 4) drive(1'b0, 4'b0000, 3'b000, 1'b0, 32'h0);
    end
    check("reraise redirects", 32'(nred), 32'h1);
    check("reraise latency", 32'(lat), 32'h4);
    check("reraise mepc writes", 32'(wr_mepc), 32'h1);
    check("reraise mcause writes", 32'(wr_mcause), 32'h1);
    check("reraise mstatus writes", 32'(wr_mstatus), 32'h1);
    check("reraise mepc", m_mepc, 32'h100);
    check("reraise mcause", m_mcause, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
